// File: rtl/darktimer_pkg.sv
// darktimer_pkg: register map offsets, CTRL bit layout and the channel control type
// shared by the timer top and its channel instances.
package darktimer_pkg;

    localparam int WORD_STATUS  = 0;
    localparam int WORD_MASK    = 1;
    localparam int CH_BASE      = 4;
    localparam int CH_STRIDE    = 4;
    localparam int SUB_RELOAD   = 0;
    localparam int SUB_CTRL     = 1;
    localparam int SUB_COUNT    = 2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;

    // Field order mirrors the CTRL word: bit1 ONESHOT, bit0 EN.
    typedef struct packed {
        logic oneshot;
        logic en;
    } chan_ctrl_t;

    function automatic chan_ctrl_t ctrl_from_word(input logic [31:0] word);
        chan_ctrl_t c;
        c.en      = word[CTRL_EN];
        c.oneshot = word[CTRL_ONESHOT];
        return c;
    endfunction

endpackage

// File: rtl/darktimer_chan.sv
// darktimer_chan: one down-counter channel with its RELOAD and CTRL registers; o_expire
// is high in every enabled cycle in which the count sits at zero.
module darktimer_chan
    import darktimer_pkg::*;
#(
    parameter int              CW         = 32,
    parameter logic            RST_EN     = 1'b0,
    parameter logic [CW-1:0]   RST_RELOAD = {CW{1'b0}}
) (
    input  logic          i_clk,
    input  logic          i_res,
    input  logic          i_wr_reload,
    input  logic          i_wr_ctrl,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [CW-1:0] o_reload,
    output chan_ctrl_t    o_ctrl,
    output logic [CW-1:0] o_count,
    output logic          o_expire
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_reload;
    logic [CW-1:0] r_cnt;
    chan_ctrl_t    r_ctrl;

    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_reload_wdata;
    chan_ctrl_t    w_ctrl_next;
    chan_ctrl_t    w_ctrl_wdata;
    logic          w_zero;
    logic          w_unused;

    assign w_zero       = (r_cnt == '0);
    assign w_ctrl_wdata = ctrl_from_word(i_wdata);

    for (genvar b = 0; b < CW; b++) begin : g_bit
        assign w_reload_wdata[b] = i_be[b/8] ? i_wdata[b] : r_reload[b];
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_cnt_next  = r_cnt;
        w_ctrl_next = r_ctrl;
        if (r_ctrl.en) begin
            if (!w_zero)
                w_cnt_next = r_cnt - CNT_ONE;
            else if (r_ctrl.oneshot)
                w_ctrl_next.en = 1'b0;
            else
                w_cnt_next = r_reload;
        end
        // A CTRL write overrides counting only when it starts or stops the channel.
        if (i_wr_ctrl && i_be[0]) begin
            w_ctrl_next = w_ctrl_wdata;
            if (!w_ctrl_wdata.en)
                w_cnt_next = r_cnt;
            else if (!r_ctrl.en)
                w_cnt_next = r_reload;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (i_res) begin
            r_reload <= RST_RELOAD;
            r_cnt    <= RST_RELOAD;
            r_ctrl   <= '{oneshot: 1'b0, en: RST_EN};
        end else begin
            r_cnt  <= w_cnt_next;
            r_ctrl <= w_ctrl_next;
            if (i_wr_reload)
                r_reload <= w_reload_wdata;
        end
    end

    assign o_reload = r_reload;
    assign o_ctrl   = r_ctrl;
    assign o_count  = r_cnt;
    assign o_expire = r_ctrl.en && w_zero;

    assign w_unused = ^i_wdata;

endmodule

// File: rtl/darktimer.sv
// darktimer: NCH-channel timer with pending/mask interrupt logic and a word-addressed
// register file on the darksocv IO bus.
module darktimer
    import darktimer_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int CW           = 32,
    parameter int RESET_RELOAD = 99
) (
    input  logic           CLK,
    input  logic           RES,
    input  logic           RD,
    input  logic           WR,
    input  logic [7:0]     ADDR,
    input  logic [3:0]     BE,
    input  logic [31:0]    DATAI,
    output logic [31:0]    DATAO,
    output logic           RACK,
    output logic           WACK,
    output logic           IRQ,
    output logic [NCH-1:0] IRQV
);

    int             w_word;
    int             w_rel;
    int             w_ch_idx;
    int             w_sub;
    logic           w_ch_sel;
    logic [NCH-1:0] w_expire;
    logic [NCH-1:0] w_pend_clr;
    logic [31:0]    w_rd_chain [NCH+1];
    logic [31:0]    w_rdata;
    logic           w_unused;

    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_mask;
    logic [31:0]    r_datao;
    logic           r_rack;

    always_comb begin
        w_word   = int'(ADDR[7:2]);
        w_rel    = w_word - CH_BASE;
        w_ch_idx = w_rel / CH_STRIDE;
        w_sub    = w_rel % CH_STRIDE;
        w_ch_sel = (w_word >= CH_BASE) && (w_ch_idx < NCH);
    end

    assign w_rd_chain[0] = '0;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        localparam logic [CW-1:0] RST_RELOAD = (n == 0) ? CW'(RESET_RELOAD) : {CW{1'b0}};

        logic          w_hit;
        logic [CW-1:0] w_reload;
        logic [CW-1:0] w_count;
        chan_ctrl_t    w_ctrl;
        logic [31:0]   w_rd;

        assign w_hit = w_ch_sel && (w_ch_idx == n);

        darktimer_chan #(
            .CW         (CW),
            .RST_EN     (n == 0),
            .RST_RELOAD (RST_RELOAD)
        ) u_chan (
            .i_clk       (CLK),
            .i_res       (RES),
            .i_wr_reload (WR && w_hit && (w_sub == SUB_RELOAD)),
            .i_wr_ctrl   (WR && w_hit && (w_sub == SUB_CTRL)),
            .i_be        (BE),
            .i_wdata     (DATAI),
            .o_reload    (w_reload),
            .o_ctrl      (w_ctrl),
            .o_count     (w_count),
            .o_expire    (w_expire[n])
        );

        always_comb begin
            w_rd = '0;
            if (w_hit) begin
                case (w_sub)
                    SUB_RELOAD: w_rd = 32'(w_reload);
                    SUB_CTRL:   w_rd = 32'(w_ctrl);
                    SUB_COUNT:  w_rd = 32'(w_count);
                    default:    w_rd = '0;
                endcase
            end
        end

        // Only the addressed channel contributes, so OR-chaining forms the read mux.
        assign w_rd_chain[n+1] = w_rd_chain[n] | w_rd;
    end

    always_comb begin
        w_pend_clr = '0;
        if (WR && (w_word == WORD_STATUS) && BE[0])
            w_pend_clr = DATAI[NCH-1:0];
    end

    always_comb begin
        w_rdata = w_rd_chain[NCH];
        if (w_word == WORD_STATUS)
            w_rdata = 32'(r_pend);
        else if (w_word == WORD_MASK)
            w_rdata = 32'(r_mask);
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_pend  <= '0;
            r_mask  <= '0;
            r_datao <= '0;
            r_rack  <= 1'b0;
        end else begin
            // Expiry is applied after the clear so a same-cycle set survives.
            r_pend <= (r_pend & ~w_pend_clr) | w_expire;
            if (WR && (w_word == WORD_MASK) && BE[0])
                r_mask <= DATAI[NCH-1:0];
            if (RD)
                r_datao <= w_rdata;
            r_rack <= RD;
        end
    end

    assign DATAO = r_datao;
    assign RACK  = r_rack;
    assign WACK  = WR;
    assign IRQV  = r_pend & r_mask;
    assign IRQ   = |IRQV;

    assign w_unused = ^ADDR[1:0];

endmodule

// File: tb/tb_darktimer.sv
// tb_darktimer: directed scenarios plus a randomized bus run checked against a
// cycle-level behavioural model of the timer register file.
module tb_darktimer;

    localparam int NCH          = 4;
    localparam int CW           = 32;
    localparam int RESET_RELOAD = 99;

    logic           CLK = 1'b0;
    logic           RES;
    logic           RD;
    logic           WR;
    logic [7:0]     ADDR;
    logic [3:0]     BE;
    logic [31:0]    DATAI;
    logic [31:0]    DATAO;
    logic           RACK;
    logic           WACK;
    logic           IRQ;
    logic [NCH-1:0] IRQV;

    int n_checks = 0;
    int n_pass   = 0;

    darktimer #(.NCH(NCH), .CW(CW), .RESET_RELOAD(RESET_RELOAD)) dut (
        .CLK(CLK), .RES(RES), .RD(RD), .WR(WR), .ADDR(ADDR), .BE(BE), .DATAI(DATAI),
        .DATAO(DATAO), .RACK(RACK), .WACK(WACK), .IRQ(IRQ), .IRQV(IRQV)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: channel state as plain numbers, one call per clock edge.
    bit [31:0]    m_cnt [NCH];
    bit [31:0]    m_rel [NCH];
    bit           m_en  [NCH];
    bit           m_os  [NCH];
    bit [NCH-1:0] m_pend;
    bit [NCH-1:0] m_mask;
    bit [31:0]    m_datao;
    bit           m_rack;

    function automatic bit [31:0] model_read(input bit [7:0] addr);
        int word, ch, sub;
        word = int'(addr[7:2]);
        ch   = (word - 4) / 4;
        sub  = (word - 4) % 4;
        if (word == 0) return 32'(m_pend);
        if (word == 1) return 32'(m_mask);
        if (word < 4 || ch >= NCH) return 32'd0;
        case (sub)
            0:       return m_rel[ch];
            1:       return {30'd0, m_os[ch], m_en[ch]};
            2:       return m_cnt[ch];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(input bit res, input bit rd, input bit wr,
                                       input bit [7:0] addr, input bit [3:0] be, input bit [31:0] d);
        int word, ch, sub;
        bit [NCH-1:0] fired;
        bit was_en;
        bit [31:0] was_cnt;
        if (res) begin
            m_pend = '0; m_mask = '0; m_datao = 32'd0; m_rack = 1'b0;
            foreach (m_cnt[n]) begin
                m_cnt[n] = 0; m_rel[n] = 0; m_en[n] = 0; m_os[n] = 0;
            end
            m_cnt[0] = RESET_RELOAD; m_rel[0] = RESET_RELOAD; m_en[0] = 1'b1;
            return;
        end
        if (rd) m_datao = model_read(addr);
        m_rack = rd;
        word  = int'(addr[7:2]);
        ch    = (word - 4) / 4;
        sub   = (word - 4) % 4;
        fired = '0;
        for (int n = 0; n < NCH; n++) begin
            was_en  = m_en[n];
            was_cnt = m_cnt[n];
            if (was_en) begin
                if (was_cnt == 0) begin
                    fired[n] = 1'b1;
                    if (m_os[n]) m_en[n] = 1'b0;
                    else         m_cnt[n] = m_rel[n];
                end else begin
                    m_cnt[n] = was_cnt - 1;
                end
            end
            if (wr && word >= 4 && ch == n) begin
                if (sub == 1 && be[0]) begin
                    if (!was_en && d[0]) m_cnt[n] = m_rel[n];
                    else if (!d[0])      m_cnt[n] = was_cnt;
                    m_en[n] = d[0];
                    m_os[n] = d[1];
                end
                if (sub == 0)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_rel[n][8*b +: 8] = d[8*b +: 8];
            end
        end
        if (wr && word == 0 && be[0]) m_pend = m_pend & ~d[NCH-1:0];
        m_pend = m_pend | fired;
        if (wr && word == 1 && be[0]) m_mask = d[NCH-1:0];
    endfunction

    task automatic tick(input bit res, input bit rd, input bit wr,
                        input bit [7:0] addr, input bit [3:0] be, input bit [31:0] d);
        RES = res; RD = rd; WR = wr; ADDR = addr; BE = be; DATAI = d;
        @(posedge CLK);
        model_step(res, rd, wr, addr, be, d);
        #1;
        RES = 1'b0; RD = 1'b0; WR = 1'b0;
    endtask

    task automatic idle();                                      tick(0, 0, 0, 8'h00, 4'h0, 32'h0); endtask
    task automatic rd_word(input bit [7:0] a);                  tick(0, 1, 0, a, 4'h0, 32'h0);     endtask
    task automatic wr_word(input bit [7:0] a, input bit [31:0] d); tick(0, 0, 1, a, 4'hF, d);      endtask
    task automatic do_reset();                                  repeat (3) tick(1, 0, 0, 8'h00, 4'h0, 32'h0); endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (DATAO !== 32'h0) $display("FAIL reset_datao: got %h want %h", DATAO, 32'h0); else n_pass++;
        n_checks++; if (RACK !== 1'b0) $display("FAIL reset_rack: got %b want 0", RACK); else n_pass++;
        n_checks++; if (IRQV !== '0 || IRQ !== 1'b0) $display("FAIL reset_irq: got %b/%b want 0", IRQV, IRQ); else n_pass++;
        rd_word(8'h10);
        n_checks++; if (DATAO !== 32'd99) $display("FAIL reset_reload0: got %0d want 99", DATAO); else n_pass++;
        rd_word(8'h14);
        n_checks++; if (DATAO !== 32'd1) $display("FAIL reset_ctrl0: got %h want 1", DATAO); else n_pass++;
        rd_word(8'h18);
        n_checks++; if (DATAO !== 32'd97) $display("FAIL reset_count0: got %0d want 97", DATAO); else n_pass++;
        rd_word(8'h24);
        n_checks++; if (DATAO !== 32'd0) $display("FAIL reset_ctrl1: got %h want 0", DATAO); else n_pass++;
    endtask

    task automatic test_ch0_period();
        int k;
        int bad;
        do_reset();
        bad = 0;
        repeat (150) begin
            idle();
            if (IRQ !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL ch0_masked_irq: got %0d high cycles want 0", bad); else n_pass++;
        rd_word(8'h00);
        n_checks++; if (DATAO !== 32'h1) $display("FAIL ch0_pend: got %h want 1", DATAO); else n_pass++;
        wr_word(8'h04, 32'h1);
        n_checks++; if (IRQ !== 1'b1) $display("FAIL ch0_irq_after_mask: got %b want 1", IRQ); else n_pass++;

        do_reset();
        wr_word(8'h04, 32'h1);
        k = 1;
        while (IRQ !== 1'b1 && k < 200) begin idle(); k++; end
        n_checks++; if (k != 100) $display("FAIL ch0_first_expiry: got cycle %0d want 100", k); else n_pass++;
        wr_word(8'h00, 32'h1);
        k++;
        n_checks++; if (IRQ !== 1'b0) $display("FAIL ch0_clear: got %b want 0", IRQ); else n_pass++;
        while (IRQ !== 1'b1 && k < 300) begin idle(); k++; end
        n_checks++; if (k != 200) $display("FAIL ch0_period: got cycle %0d want 200", k); else n_pass++;
    endtask

    task automatic test_oneshot();
        int k;
        int bad;
        wr_word(8'h04, 32'h2);
        wr_word(8'h20, 32'd5);
        wr_word(8'h24, 32'h3);
        k = 0;
        while (IRQV[1] !== 1'b1 && k < 50) begin idle(); k++; end
        n_checks++; if (k != 6) $display("FAIL oneshot_delay: got %0d want 6", k); else n_pass++;
        rd_word(8'h24);
        n_checks++; if (DATAO !== 32'h2) $display("FAIL oneshot_ctrl: got %h want 2", DATAO); else n_pass++;
        rd_word(8'h28);
        n_checks++; if (DATAO !== 32'h0) $display("FAIL oneshot_count: got %h want 0", DATAO); else n_pass++;
        wr_word(8'h00, 32'h2);
        bad = 0;
        repeat (30) begin
            idle();
            if (IRQV[1] !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL oneshot_rearm: got %0d high cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_set_wins();
        int bad;
        wr_word(8'h04, 32'h4);
        wr_word(8'h30, 32'd0);
        wr_word(8'h34, 32'h1);
        idle();
        n_checks++; if (IRQV[2] !== 1'b1) $display("FAIL setwins_first: got %b want 1", IRQV[2]); else n_pass++;
        bad = 0;
        repeat (30) begin
            tick(0, 0, 1, 8'h00, 4'h1, 32'h4);
            if (IRQV[2] !== 1'b1 || IRQ !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL setwins_hold: got %0d low cycles want 0", bad); else n_pass++;
        wr_word(8'h34, 32'h0);
        wr_word(8'h00, 32'hF);
    endtask

    task automatic test_byte_lane();
        wr_word(8'h40, 32'h11223344);
        tick(0, 0, 1, 8'h40, 4'b0010, 32'h0000AB00);
        n_checks++; if (RACK !== 1'b0) $display("FAIL lane_rack_idle: got %b want 0", RACK); else n_pass++;
        rd_word(8'h40);
        n_checks++; if (RACK !== 1'b1) $display("FAIL lane_rack: got %b want 1", RACK); else n_pass++;
        n_checks++; if (DATAO !== 32'h1122AB44) $display("FAIL lane_data: got %h want 1122ab44", DATAO); else n_pass++;
        idle();
        n_checks++; if (RACK !== 1'b0) $display("FAIL lane_rack_pulse: got %b want 0", RACK); else n_pass++;
        n_checks++; if (DATAO !== 32'h1122AB44) $display("FAIL lane_hold: got %h want 1122ab44", DATAO); else n_pass++;
    endtask

    task automatic test_unmapped();
        bit [7:0] holes [3];
        holes[0] = 8'h0C; holes[1] = 8'h60; holes[2] = 8'h1C;
        for (int i = 0; i < 3; i++) begin
            rd_word(8'h40);
            rd_word(holes[i]);
            n_checks++; if (DATAO !== 32'h0) $display("FAIL unmapped_%h: got %h want 0", holes[i], DATAO); else n_pass++;
        end
        wr_word(8'h60, 32'hFFFFFFFF);
        rd_word(8'h60);
        n_checks++; if (DATAO !== 32'h0) $display("FAIL unmapped_wr: got %h want 0", DATAO); else n_pass++;
        wr_word(8'h04, 32'hFFFFFFFF);
        rd_word(8'h04);
        n_checks++; if (DATAO !== 32'hF) $display("FAIL mask_width: got %h want f", DATAO); else n_pass++;
        wr_word(8'h04, 32'h0);
    endtask

    task automatic test_write_ack();
        RD = 1'b0; WR = 1'b1; ADDR = 8'h0C; BE = 4'hF; DATAI = 32'h0;
        #1;
        n_checks++; if (WACK !== 1'b1) $display("FAIL wack_high: got %b want 1", WACK); else n_pass++;
        WR = 1'b0;
        #1;
        n_checks++; if (WACK !== 1'b0) $display("FAIL wack_low: got %b want 0", WACK); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit [7:0] ctrls [3];
        ctrls[0] = 8'h24; ctrls[1] = 8'h34; ctrls[2] = 8'h44;
        wr_word(8'h20, 32'd3);
        wr_word(8'h24, 32'h1);
        wr_word(8'h34, 32'h1);
        wr_word(8'h40, 32'd7);
        wr_word(8'h44, 32'h1);
        wr_word(8'h04, 32'hF);
        repeat (10) idle();
        tick(1, 1, 1, 8'h24, 4'hF, 32'h3);
        n_checks++; if (RACK !== 1'b0 || DATAO !== 32'h0) $display("FAIL rstmid_bus: got %b/%h want 0/0", RACK, DATAO); else n_pass++;
        n_checks++; if (IRQV !== '0) $display("FAIL rstmid_irqv: got %b want 0", IRQV); else n_pass++;
        rd_word(8'h18);
        n_checks++; if (DATAO !== 32'd99) $display("FAIL rstmid_count0: got %0d want 99", DATAO); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            rd_word(ctrls[i]);
            n_checks++; if (DATAO !== 32'h0) $display("FAIL rstmid_ctrl%0d: got %h want 0", i + 1, DATAO); else n_pass++;
        end
        rd_word(8'h00);
        n_checks++; if (DATAO !== 32'h0) $display("FAIL rstmid_pend: got %h want 0", DATAO); else n_pass++;
    endtask

    task automatic test_random();
        int w, op, sub;
        bit [7:0] a;
        bit [3:0] be;
        bit [31:0] d;
        bit rd, wr;
        for (int i = 0; i < 3000; i++) begin
            w  = $urandom_range(0, 27);
            op = $urandom_range(0, 19);
            rd = (op < 8) || (op == 19);
            wr = (op >= 8 && op < 16) || (op == 19);
            a  = 8'((w << 2) | $urandom_range(0, 3));
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            sub = (w - 4) % 4;
            if (w >= 4 && sub == 0)      d = $urandom_range(0, 15);
            else if (w >= 4 && sub == 1) d = $urandom_range(0, 3);
            else                         d = $urandom;
            tick(0, rd, wr, a, be, d);
            n_checks++; if (DATAO !== m_datao) $display("FAIL rand_datao@%0d: got %h want %h", i, DATAO, m_datao); else n_pass++;
            n_checks++; if (RACK !== m_rack) $display("FAIL rand_rack@%0d: got %b want %b", i, RACK, m_rack); else n_pass++;
            n_checks++; if (IRQV !== (m_pend & m_mask)) $display("FAIL rand_irqv@%0d: got %b want %b", i, IRQV, m_pend & m_mask); else n_pass++;
            n_checks++; if (IRQ !== |(m_pend & m_mask)) $display("FAIL rand_irq@%0d: got %b want %b", i, IRQ, |(m_pend & m_mask)); else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RES = 1'b1; RD = 1'b0; WR = 1'b0; ADDR = 8'h0; BE = 4'h0; DATAI = 32'h0;
        test_reset();
        test_ch0_period();
        test_oneshot();
        test_set_wins();
        test_byte_lane();
        test_unmapped();
        test_write_ack();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/darktimer.md
# darktimer

Parametrised multi-channel timer and interrupt controller for the darksocv IO space. It generalises the single 1 MHz timer/IREQ-IACK pair to NCH independent down-counters, each periodic or one-shot. It adds per-channel pending bits, an interrupt mask and a memory-mapped register file. It sits on the core data bus behind the DADDR[31] IO decode and drives the core interrupt line.

## Interface
- NCH, 4: number of timer channels, 1..8
- CW, 32: counter/reload width, 8..32
- RESET_RELOAD, 99: channel 0 reload after reset (`BOARD_CK`/1 MHz − 1)
- CLK  in  1  single clock, all logic rising-edge
- RES  in  1  reset, synchronous, active-high
- RD  in  1  read strobe, already qualified by IO decode and !HLT
- WR  in  1  write strobe, same qualification
- ADDR  in  8  byte address within block; ADDR[7:2] selects the word
- BE  in  4  byte enables for writes
- DATAI  in  32  write data
- DATAO  out  32  registered read data
- RACK  out  1  read acknowledge
- WACK  out  1  write acknowledge
- IRQ  out  1  OR of (PEND & MASK)
- IRQV  out  NCH  PEND & MASK per channel

## Operation
- Word map (ADDR[7:2]):
  - 0 STATUS: PEND[NCH-1:0]; write-1-to-clear, BE[0] only.
  - 1 MASK: MASK[NCH-1:0], R/W.
  - 4+4n RELOAD_n: CW bits, R/W, byte-enable honoured.
  - 5+4n CTRL_n: bit0 EN, bit1 ONESHOT.
  - 6+4n COUNT_n: read-only.
  - Other words and channels ≥NCH read 0; writes to them are ignored.
- Channel counting while EN=1:
  - CNT≠0: CNT ← CNT−1.
  - CNT=0: PEND[n] ← 1.
    - Periodic: CNT ← RELOAD, so the period is RELOAD+1 cycles.
    - One-shot: EN ← 0 and CNT stays 0.
- RELOAD=0 with EN=1 periodic: PEND is set every cycle.
- Writing CTRL with EN going 0→1 loads CNT ← RELOAD in that cycle; counting starts on the next cycle.
- Writing CTRL with EN=1 while already running leaves CNT untouched.
- Writing EN=0 freezes CNT.
- Writing RELOAD while running takes effect at the next reload; CNT is not modified.
- If a clear and an expiry of the same channel occur in the same cycle, the set wins and PEND stays 1.
- Writes narrower than the register update only enabled bytes. Bits above CW or NCH are ignored on write and read as 0.
- Reset state:
  - PEND=0, MASK=0, DATAO=0, RACK=0.
  - Channel 0: RELOAD=RESET_RELOAD, CNT=RESET_RELOAD, EN=1, ONESHOT=0. This matches the legacy free-running timer.
  - Other channels: all 0.
- Reset mid-operation overrides any concurrent WR or RD.

## Timing
- Write: 0 wait states; WACK=WR combinationally. The register updates on the same edge.
- Read: RD in cycle t gives DATAO and RACK=1 in cycle t+1. RACK lasts one cycle, and DATAO holds until the next read.
- The read value is the register content before the edge that samples RD. A COUNT read returns CNT as of cycle t.
- IRQ/IRQV are combinational from registered PEND and MASK. They rise the cycle after the CNT=0 cycle.
- Simultaneous RD and WR in the same cycle is not issued by the core; if it occurs, the write performs and the read returns pre-write data.

## Structure
- Package darktimer_pkg holds:
  - word offsets: STATUS, MASK, CH_BASE=4, CH_STRIDE=4, RELOAD/CTRL/COUNT sub-offsets
  - CTRL bit indices: EN=0, ONESHOT=1
  - packed struct for channel control
- Sub-module darktimer_chan: one channel (CNT, RELOAD, CTRL, expiry pulse output). The top is a generate loop of NCH instances plus the address decode, PEND/MASK and read mux.

## Test plan
- Reset release, no access → channel 0 sets PEND[0] at cycle 100 and every 100 cycles after; IRQ stays 0 (MASK=0). After write MASK=1, IRQ=1.
- Ch1 RELOAD=5, CTRL=3 (one-shot) → PEND[1] set exactly 6 cycles after the CTRL write. Then CTRL reads 2, COUNT reads 0, with no further expiry.
- Ch2 RELOAD=0, periodic, MASK=4; write STATUS=4 every cycle → PEND[2] is never observed 0 (set wins) and IRQV[2] stays 1.
- Write RELOAD_3 byte lane BE=4'b0010 with DATAI=0x0000AB00 over 0x11223344 → reads back 0x1122AB44 with RD→RACK latency 1.
- Read unmapped word 3 and channel 5 with NCH=4 → DATAO=0. Assert RES mid-count → all channels except ch0 are disabled, PEND=0 and ch0 COUNT=99 on the next read.
